mem_responder: RTL
==================

Name: mem_responder

Overview:
- Bus-functional memory responder for the core's instruction or data memory port: the responder end of the req/gnt + recv/ack protocol.
- Accepts requests with programmable grant stall and serves them from a small internal word RAM.
- Queues up to MAX_OUTSTANDING responses and returns each after a programmable delay, with optional error injection.
- Used in simulation benches and as a concrete memory model behind the core's fetch and load/store ports.

Parameters:
- MEM_BASE, 32'h0000_0000, byte address of RAM word 0.
- DEPTH_WORDS, 256, number of 32-bit RAM words; power of two.
- MAX_OUTSTANDING, 3, response FIFO depth (accepted requests not yet acked); range 1..15.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- mem_req  in  1  request valid
- mem_gnt  out  1  request accepted this cycle when mem_req && mem_gnt
- mem_wen  in  1  1 = write, 0 = read
- mem_strb  in  4  byte-lane write strobes
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_recv  out  1  response valid
- mem_ack  in  1  response consumed when mem_recv && mem_ack
- mem_error  out  1  response carries a bus error; valid with mem_recv
- mem_rdata  out  32  read data; valid with mem_recv
- cfg_gnt_stall  in  3  cycles mem_req must be held before grant
- cfg_rsp_delay  in  3  cycles a head-of-FIFO response waits before mem_recv
- err_inject  in  1  force an error on the request accepted this cycle
- outstanding  out  4  current FIFO occupancy
- proto_err  out  1  sticky requester protocol-violation flag

Behaviour:
- Reset: synchronous; while reset=1 mem_gnt=0. Registered outputs next cycle: mem_recv=0, mem_error=0, mem_rdata=0, outstanding=0, proto_err=0. FIFO and all counters are cleared. RAM contents are not reset and are retained across reset. Reset mid-transaction drops all queued responses; no recv appears for them.
- Grant:
  - stall_cnt (3b) increments each cycle mem_req && !mem_gnt, saturating at 7.
  - stall_cnt clears on accept or when mem_req=0.
  - mem_gnt = mem_req && !reset && stall_cnt >= cfg_gnt_stall && outstanding < MAX_OUTSTANDING. This is combinational from registered state and mem_req.
  - A full FIFO blocks grant even if a pop occurs the same cycle.
- Accept (mem_req && mem_gnt):
  - Word index = (mem_addr - MEM_BASE) >> 2.
  - In range means mem_addr >= MEM_BASE and index < DEPTH_WORDS.
  - err = !in_range || err_inject.
  - Write, !err: RAM byte i updated from mem_wdata[8i+7:8i] where mem_strb[i]=1, at the clock edge. Queued rdata = 0.
  - Read, !err: queued rdata = RAM word at index (pre-write value; a single port never reads and writes on the same accept). Full word is returned regardless of mem_strb.
  - err: no RAM write; queued rdata = 0, error = 1.
  - Push {rdata, error} into the FIFO; outstanding increments the next cycle.
- Response:
  - dly_cnt increments each cycle the FIFO is non-empty and mem_recv=0.
  - dly_cnt clears on pop or when the FIFO is empty.
  - mem_recv = FIFO non-empty && dly_cnt >= cfg_rsp_delay, registered. mem_rdata and mem_error present the FIFO head while mem_recv=1, else 0.
  - Earliest recv is 1 cycle after accept (cfg_rsp_delay=0).
  - Once raised, mem_recv holds with stable data until mem_ack.
  - Pop on mem_recv && mem_ack. The next entry follows the delay rule again: with delay 0 it appears the next cycle, allowing back-to-back recv.
  - Push and pop in the same cycle leaves outstanding unchanged.
  - Responses are returned strictly in acceptance order.
- Protocol check: proto_err sets (sticky until reset) when either:
  - mem_req falls while previously high and ungranted; or
  - mem_addr, mem_wen, mem_strb or mem_wdata change while mem_req is held ungranted.
- Widths: all pointer and occupancy arithmetic wraps modulo FIFO depth; outstanding never exceeds MAX_OUTSTANDING.

Test Plan:
- Write then read: cfg 0/0. Write addr 0x10, wdata 0xDEADBEEF, strb 4'hF, granted the same cycle, recv next cycle with error=0, rdata=0, ack. Then read 0x10 -> recv rdata 0xDEADBEEF.
- Byte strobes: after the above, write 0x10 wdata 0x00000055 strb 4'b0001, then read -> rdata 0xDEADBE55.
- Grant stall: cfg_gnt_stall=2, hold a read request -> mem_gnt low 2 cycles, high on the 3rd. Dropping mem_req after 1 cycle -> proto_err=1 and stays 1.
- Backpressure/full: MAX_OUTSTANDING=3, cfg_rsp_delay=0, hold mem_ack=0, issue 4 reads -> 3 granted, outstanding=3, 4th stalls. Ack one -> outstanding 2 then 4th granted. Responses return in order.
- Errors: read addr MEM_BASE+4*DEPTH_WORDS (0x400) -> recv error=1, rdata=0. Write 0x20 with err_inject=1 -> error=1 and a later read of 0x20 returns the prior contents.
- Reset mid-flight: 2 reads queued with cfg_rsp_delay=5, assert reset 1 cycle -> outstanding=0, mem_recv never asserts for them, and RAM data written before reset still reads back.

Source files
------------

// File: rtl/mem_responder.sv
// Bus-functional memory responder: req/gnt accept into a word RAM, recv/ack response FIFO.
// Latency: gnt after cfg_gnt_stall held cycles; recv cfg_rsp_delay+1 cycles after accept; full FIFO withholds gnt.
module mem_responder_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [3:0]       count
);
  // Storage FIFO: zero-latency head, no internal guard (caller never pushes full / pops empty).
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      count <= count + {3'b000, push} - {3'b000, pop};
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module mem_responder #(
  parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
  parameter int          DEPTH_WORDS     = 256,
  parameter int          MAX_OUTSTANDING = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_req,
  output logic        mem_gnt,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic        mem_error,
  output logic [31:0] mem_rdata,
  input  logic [2:0]  cfg_gnt_stall,
  input  logic [2:0]  cfg_rsp_delay,
  input  logic        err_inject,
  output logic [3:0]  outstanding,
  output logic        proto_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  logic [31:0] ram [DEPTH_WORDS];

  logic [29:0]   word_off;
  logic [AW-1:0] word_idx;
  logic          in_range, err, accept, pop;
  logic [2:0]    stall_cnt, stall_nxt, dly_cnt, dly_nxt;
  logic          recv_q, recv_nxt;
  logic [3:0]    count, count_nxt;
  rsp_t          push_dat, head_dat;
  req_t          req_cur, req_held;
  logic          req_pend;

  // MEM_BASE is word aligned, so the word offset can be formed on address bits [31:2].
  assign word_off = mem_addr[31:2] - MEM_BASE[31:2];
  assign word_idx = word_off[AW-1:0];
  assign in_range = (mem_addr >= MEM_BASE) && ({2'b00, word_off} < 32'(DEPTH_WORDS));
  assign err      = !in_range || err_inject;

  assign mem_gnt = mem_req && !reset && (stall_cnt >= cfg_gnt_stall) &&
                   (count < 4'(MAX_OUTSTANDING));
  assign accept  = mem_req && mem_gnt;
  assign pop     = recv_q && mem_ack;

  always_comb begin
    push_dat.error = err;
    push_dat.rdata = (!mem_wen && !err) ? ram[word_idx] : 32'h0;
  end

  always_ff @(posedge clock) begin
    if (accept && mem_wen && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_strb[i]) ram[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  mem_responder_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (accept),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

  // recv is registered from next-cycle occupancy and wait count so delay 0 answers one cycle after accept.
  always_comb begin
    stall_nxt = stall_cnt;
    if (!mem_req || mem_gnt)   stall_nxt = 3'd0;
    else if (stall_cnt != 3'd7) stall_nxt = stall_cnt + 3'd1;

    count_nxt = count + {3'b000, accept} - {3'b000, pop};

    dly_nxt = dly_cnt;
    if (pop || count == 4'd0)            dly_nxt = 3'd0;
    else if (!recv_q && dly_cnt != 3'd7) dly_nxt = dly_cnt + 3'd1;

    recv_nxt = (count_nxt != 4'd0) && ((recv_q && !pop) || (dly_nxt >= cfg_rsp_delay));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= 3'd0;
      dly_cnt   <= 3'd0;
      recv_q    <= 1'b0;
    end else begin
      stall_cnt <= stall_nxt;
      dly_cnt   <= dly_nxt;
      recv_q    <= recv_nxt;
    end
  end

  assign req_cur = '{addr: mem_addr, wen: mem_wen, strb: mem_strb, wdata: mem_wdata};

  always_ff @(posedge clock) begin
    if (reset) begin
      proto_err <= 1'b0;
      req_pend  <= 1'b0;
      req_held  <= '0;
    end else begin
      if (req_pend && (!mem_req || req_cur != req_held)) proto_err <= 1'b1;
      req_pend <= mem_req && !mem_gnt;
      req_held <= req_cur;
    end
  end

  assign mem_recv    = recv_q;
  assign mem_rdata   = recv_q ? head_dat.rdata : 32'h0;
  assign mem_error   = recv_q ? head_dat.error : 1'b0;
  assign outstanding = count;
endmodule
